// File: rtl/mod_arith_pkg.sv
// Shared types and helpers for the serial modular-arithmetic datapaths.
package mod_arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // One conditional subtraction: brings x in [0, 2m) back into [0, m).
    function automatic logic [31:0] mod_reduce1(input logic [31:0] x, input logic [31:0] m);
        return (x >= m) ? x - m : x;
    endfunction

    // Legal parameter set: 2^(w-1) < mod < 2^w and const_b fits in w bits.
    function automatic bit params_ok(input int mod, input int w, input int const_b);
        if (w < 2 || w > 30) begin
            return 1'b0;
        end
        return (mod > (1 << (w - 1))) && (mod < (1 << w)) &&
               (const_b >= 0) && (const_b < (1 << w));
    endfunction

endpackage

// File: rtl/mod_step.sv
// One MSB-first interleaved modular multiply step: (2*acc + bit*a) mod MOD.
// acc and a must both be < MOD, so W+1 bits hold every intermediate value.
module mod_step
    import mod_arith_pkg::*;
#(
    parameter int MOD = 47,
    parameter int W   = 6
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] a,
    input  logic         b_bit,
    output logic [W-1:0] acc_next
);

    logic [W:0] dbl;
    logic [W:0] dbl_red;
    logic [W:0] sum;

    // Double, reduce, conditionally add the multiplicand, reduce again.
    always_comb begin
        dbl      = {acc, 1'b0};
        dbl_red  = (W+1)'(mod_reduce1(32'(dbl), 32'(MOD)));
        sum      = dbl_red + (b_bit ? {1'b0, a} : '0);
        acc_next = W'(mod_reduce1(32'(sum), 32'(MOD)));
    end

endmodule

// File: rtl/mod_mul_serial.sv
// Bit-serial (a * b) mod MOD with valid/ready on both sides and an optional
// constant multiplier. One multiplier bit is consumed per RUN cycle.
module mod_mul_serial
    import mod_arith_pkg::*;
#(
    parameter int MOD     = 47,
    parameter int W       = 6,
    parameter int CONST_B = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         use_const,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam int               CNT_W    = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W - 1);
    localparam logic [W-1:0]     MOD_W    = W'(MOD);
    localparam logic [W-1:0]     CONST_W  = W'(CONST_B);

    // Refuse to elaborate with a modulus that breaks the two-subtract step.
    if (!params_ok(MOD, W, CONST_B)) begin : g_param_check
        $error("mod_mul_serial: illegal MOD/W/CONST_B combination");
    end

    state_e           state_q, state_d;
    logic [W-1:0]     a_r_q, a_r_d;
    logic [W-1:0]     b_r_q, b_r_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     data_q, data_d;
    logic [W-1:0]     step_acc;
    logic             accept;

    mod_step #(
        .MOD (MOD),
        .W   (W)
    ) u_step (
        .acc      (acc_q),
        .a        (a_r_q),
        .b_bit    (b_r_q[cnt_q]),
        .acc_next (step_acc)
    );

    // Input handshake: a finished result being consumed frees the slot at once.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

    // Next-state logic: operand capture, serial stepping and result hand-off.
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_r_d   = a_r_q;
        b_r_d   = b_r_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;

        case (state_q)
            RUN: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    data_d  = step_acc;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            a_r_d   = (in_a >= MOD_W) ? in_a - MOD_W : in_a;
            b_r_d   = use_const ? CONST_W : in_b;
            acc_d   = '0;
            cnt_d   = CNT_INIT;
            state_d = RUN;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_r_q   <= '0;
            b_r_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            a_r_q   <= a_r_d;
            b_r_q   <= b_r_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_mod_mul_serial.sv
// Scoreboard bench for mod_mul_serial (MOD=47, W=6, CONST_B=18).
module tb_mod_mul_serial;

    localparam int MOD     = 47;
    localparam int W       = 6;
    localparam int CONST_B = 18;
    localparam int BOUND   = 100;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         use_const;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W-1:0] exp_q[$];

    mod_mul_serial #(
        .MOD     (MOD),
        .W       (W),
        .CONST_B (CONST_B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .use_const (use_const),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] model(input int a, input int b, input bit uc);
        int bb;
        bb = uc ? CONST_B : b;
        return W'(((a % MOD) * bb) % MOD);
    endfunction

    // Offer one pair and return #1 after the edge that accepts it.
    task automatic send(input int a, input int b, input bit uc, output int acc_cyc);
        int n;
        @(negedge clk);
        in_a      = W'(a);
        in_b      = W'(b);
        use_const = uc;
        in_valid  = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < BOUND) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_accept: in_ready=%0b required 1 within %0d cycles", in_ready, BOUND);
        end
        exp_q.push_back(model(a, b, uc));
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid rises, sampling #1 after each edge.
    task automatic wait_valid(output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < BOUND) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        use_const = 1'b0;
        out_ready = 1'b1;
        #23;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %0b required 0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_out_data: got %0d required 0", out_data);
        end
    endtask

    // Single operation with out_ready high: checks latency, value, one transfer.
    task automatic run_one(input string name, input int a, input int b, input bit uc);
        int acc_cyc, lat;
        bit ok;
        logic [W-1:0] exp;
        out_ready = 1'b1;
        send(a, b, uc, acc_cyc);
        wait_valid(lat, ok);
        checks++;
        if (!ok || lat != W) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges (valid=%0b) required %0d", name, lat, ok, W);
        end
        exp = exp_q.pop_front();
        checks++;
        if (out_data !== exp) begin
            errors++;
            $display("FAIL %s_data: got %0d required %0d", name, out_data, exp);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: out_valid=%0b required 0 after transfer", name, out_valid);
        end
    endtask

    task automatic test_basic;
        run_one("basic_5x10", 5, 10, 1'b0);
        run_one("basic_0x37", 0, 37, 1'b0);
        run_one("basic_29x0", 29, 0, 1'b0);
    endtask

    task automatic test_const;
        run_one("const_a1", 1, 63, 1'b1);
        run_one("const_a46", 46, 63, 1'b1);
    endtask

    task automatic test_prereduce;
        run_one("pre_50x63", 50, 63, 1'b0);
        run_one("pre_63x63", 63, 63, 1'b0);
        run_one("pre_46x46", 46, 46, 1'b0);
    endtask

    task automatic test_backpressure;
        int acc_cyc, lat;
        bit ok;
        logic [W-1:0] exp, held;
        out_ready = 1'b0;
        send(12, 34, 1'b0, acc_cyc);
        wait_valid(lat, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_valid: out_valid=%0b required 1", out_valid);
        end
        exp  = exp_q.pop_front();
        held = out_data;
        checks++;
        if (held !== exp) begin
            errors++;
            $display("FAIL bp_data: got %0d required %0d", held, exp);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = W'(i + 3);
            in_b     = W'(i + 9);
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
                errors++;
                $display("FAIL bp_hold_%0d: in_ready=%0b out_valid=%0b out_data=%0d required 0/1/%0d",
                         i, in_ready, out_valid, out_data, held);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%0b required 0 after one transfer", out_valid);
        end
        // The ignored pulses must not have left a queued operation behind.
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_idle_%0d: out_valid=%0b in_ready=%0b required 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc_cycs[3];
        int out_cycs[3];
        int as[3];
        int bs[3];
        bit ucs[3];
        as  = '{5, 20, 40};
        bs  = '{10, 30, 2};
        ucs = '{1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    int n;
                    @(negedge clk);
                    in_a      = W'(as[i]);
                    in_b      = W'(bs[i]);
                    use_const = ucs[i];
                    in_valid  = 1'b1;
                    #1;
                    n = 0;
                    while (!in_ready && n < BOUND) begin
                        @(negedge clk);
                        #1;
                        n++;
                    end
                    exp_q.push_back(model(as[i], bs[i], ucs[i]));
                    @(posedge clk);
                    #1;
                    acc_cycs[i] = cyc;
                end
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    int n;
                    logic [W-1:0] exp;
                    n = 0;
                    @(posedge clk);
                    #1;
                    while (!out_valid && n < BOUND) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    out_cycs[i] = cyc;
                    checks++;
                    if (!out_valid || exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL b2b_valid_%0d: out_valid=%0b queued=%0d", i, out_valid, exp_q.size());
                    end else begin
                        exp = exp_q.pop_front();
                        checks++;
                        if (out_data !== exp) begin
                            errors++;
                            $display("FAIL b2b_data_%0d: got %0d required %0d", i, out_data, exp);
                        end
                    end
                end
            end
        join
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (out_cycs[i] - out_cycs[i-1] != W + 1) begin
                errors++;
                $display("FAIL b2b_spacing_%0d: got %0d cycles required %0d", i, out_cycs[i] - out_cycs[i-1], W + 1);
            end
            // Result i-1 is consumed on the edge after it is seen; pair i is accepted on that same edge.
            checks++;
            if (acc_cycs[i] != out_cycs[i-1] + 1) begin
                errors++;
                $display("FAIL b2b_accept_%0d: accepted at cycle %0d required %0d", i, acc_cycs[i], out_cycs[i-1] + 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int acc_cyc, lat;
        bit ok;
        logic [W-1:0] exp;
        out_ready = 1'b1;
        send(33, 44, 1'b0, acc_cyc);
        void'(exp_q.pop_back());
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: out_valid=%0b in_ready=%0b out_data=%0d required 0/1/0",
                     out_valid, in_ready, out_data);
        end
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_partial_%0d: out_valid=%0b required 0", i, out_valid);
            end
        end
        send(7, 7, 1'b0, acc_cyc);
        wait_valid(lat, ok);
        checks++;
        if (!ok || lat != W) begin
            errors++;
            $display("FAIL midreset_latency: got %0d edges (valid=%0b) required %0d", lat, ok, W);
        end
        exp = exp_q.pop_front();
        checks++;
        if (out_data !== exp) begin
            errors++;
            $display("FAIL midreset_data: got %0d required %0d", out_data, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_const();
        test_prereduce();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d results still expected, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
